load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 28 ++
 rtl/load_store_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
//------------------------------------------------------------------------------
// load_store_unit_pkg
//
// Purpose : Shared definitions for the load/store unit. Holds the default
//           address and data widths, the width of the transaction counters,
//           and the 2-bit encoding of the unit's control state machine.
//
// Contents:
//   ADDR_W_DEF   default data-memory address width
//   DATA_W_DEF   default data word width
//   CNT_W        width of the completed-load / completed-store counters
//   lsu_state_t  FSM states: IDLE, RD (memory read), WR (memory write),
//                RESP (response held until the core accepts it)
//------------------------------------------------------------------------------
package load_store_unit_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;
    localparam int CNT_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_t;

endpackage : load_store_unit_pkg

// File: rtl/load_store_unit.sv
//------------------------------------------------------------------------------
// load_store_unit
//
// Purpose : Bridges a valid/ready load/store request channel from the core to
//           a simple single-port data memory, and returns a valid/ready
//           response. One transaction is in flight at a time:
//             IDLE -> RD   -> RESP -> IDLE   (load)
//             IDLE -> WR   -> RESP -> IDLE   (store)
//           With the response accepted immediately, a new request can be
//           taken every third clock.
//
// Parameters:
//   ADDR_W  data-memory address width
//   DATA_W  data word width
//
// Ports:
//   clock, reset_n              single rising-edge clock, async active-low reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_write                   1 = store, 0 = load
//   req_addr, req_wdata         request address and store data
//   resp_valid/resp_ready       response handshake
//   resp_data                   load data, or the stored data for a store
//   resp_is_write               response belongs to a store
//   mem_address, mem_write_data data-memory address / write data (registered)
//   mem_read, mem_write         one-cycle data-memory strobes, never together
//   mem_data_in                 data-memory read data
//   load_count, store_count     completed-transaction counters (wrap at 255)
//------------------------------------------------------------------------------
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,

    // Request channel from the core
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,

    // Response channel to the core
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_is_write,

    // Data-memory interface
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_data_in,

    // Completed-transaction counters
    output logic [CNT_W-1:0]  load_count,
    output logic [CNT_W-1:0]  store_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    //--------------------------------------------------------------------------
    // State and registered request fields
    //--------------------------------------------------------------------------
    lsu_state_t        r_state;
    lsu_state_t        w_next_state;

    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_write;

    logic [DATA_W-1:0] r_resp_data;
    logic              r_resp_is_write;

    logic [CNT_W-1:0]  r_load_count;
    logic [CNT_W-1:0]  r_store_count;

    // Decoded FSM outputs
    logic              w_idle;
    logic              w_mem_read;
    logic              w_mem_write;
    logic              w_resp_valid;

    // Handshake events
    logic              w_accept;
    logic              w_resp_done;

    assign w_accept    = w_idle & req_valid;
    assign w_resp_done = w_resp_valid & resp_ready;

    //--------------------------------------------------------------------------
    // FSM state register
    //--------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values of the others, independent of block ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    //--------------------------------------------------------------------------
    // FSM next-state and output decode
    //--------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_idle       = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_resp_valid = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                w_idle = 1'b1;
                if (req_valid) begin
                    w_next_state = req_write ? ST_WR : ST_RD;
                end
            end
            ST_RD: begin
                // Memory samples the address on the falling edge; the data is
                // captured on the rising edge that leaves this state.
                w_mem_read   = 1'b1;
                w_next_state = ST_RESP;
            end
            ST_WR: begin
                // Memory commits the write on the rising edge leaving this state.
                w_mem_write  = 1'b1;
                w_next_state = ST_RESP;
            end
            ST_RESP: begin
                w_resp_valid = 1'b1;
                if (resp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Request capture. The memory only ever sees these registered copies, so
    // req_* may change freely once the request has been accepted.
    //--------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
        end else if (w_accept) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_write <= req_write;
        end
    end

    //--------------------------------------------------------------------------
    // Response payload. Loaded on the edge that leaves RD/WR and untouched in
    // RESP, so it stays stable for as long as the core stalls.
    //--------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_resp_data     <= '0;
            r_resp_is_write <= 1'b0;
        end else begin
            if (r_state == ST_RD) begin
                r_resp_data     <= mem_data_in;
                r_resp_is_write <= 1'b0;
            end else if (r_state == ST_WR) begin
                r_resp_data     <= r_wdata;
                r_resp_is_write <= 1'b1;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Completed-transaction counters: bump on the response handshake, so a
    // transaction cut short by reset is never counted. Natural 8-bit wrap.
    //--------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_load_count  <= '0;
            r_store_count <= '0;
        end else if (w_resp_done) begin
            if (r_resp_is_write) begin
                r_store_count <= r_store_count + CNT_ONE;
            end else begin
                r_load_count  <= r_load_count + CNT_ONE;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    // The state already reads IDLE while reset is held; gating with reset_n
    // keeps the core from seeing ready until reset is released.
    assign req_ready      = w_idle & reset_n;

    assign resp_valid     = w_resp_valid;
    assign resp_data      = r_resp_data;
    assign resp_is_write  = r_resp_is_write;

    assign mem_address    = r_addr;
    assign mem_write_data = r_wdata;
    assign mem_read       = w_mem_read;
    assign mem_write      = w_mem_write;

    assign load_count     = r_load_count;
    assign store_count    = r_store_count;

endmodule : load_store_unit

// File: tb/tb_load_store_unit.sv
//------------------------------------------------------------------------------
// tb_load_store_unit
//
// Self-checking bench for load_store_unit. A behavioural data memory sits on
// the mem_* port. Stimulus pushes the expected response of every request into
// a scoreboard queue, computed from a plain array model of memory contents;
// an independent monitor pops and compares on each response handshake.
//------------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              is_write;
    } exp_t;

    logic              clock;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic              resp_is_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_data_in;
    logic [7:0]        load_count;
    logic [7:0]        store_count;

    load_store_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .resp_is_write  (resp_is_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_data_in    (mem_data_in),
        .load_count     (load_count),
        .store_count    (store_count)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   exp_loads  = 0;
    int   exp_stores = 0;
    logic rr_random  = 1'b0;
    exp_t sb[$];
    logic [DATA_W-1:0] mem_model [16];

    function automatic logic [DATA_W-1:0] init_val(input int i);
        case (i)
            0:       return 8'd1;
            1:       return 8'd15;
            2:       return 8'd5;
            default: return 8'(8'h30 + i * 7);
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Clock and cycle counter
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // Behavioural data memory: reads sampled on the falling edge while
    // mem_read is high, writes committed on the rising edge while mem_write is high.
    logic [DATA_W-1:0] mem [16];
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = init_val(i);
        mem_data_in = '0;
        forever begin
            @(clock);
            if (!clock && mem_read) begin
                mem_data_in <= mem[mem_address];
            end else if (clock && mem_write) begin
                mem[mem_address] = mem_write_data;
            end
        end
    end

    // Response-ready driver for randomized back-pressure
    initial forever begin
        @(posedge clock);
        #1;
        if (rr_random) resp_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: strobe exclusivity every cycle, scoreboard on each handshake
    initial forever begin
        @(negedge clock);
        if (reset_n) begin
            check("mem_rd_wr_exclusive", {31'b0, mem_read & mem_write}, 32'd0);
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: data=0x%0h is_write=%0b with empty scoreboard",
                             resp_data, resp_is_write);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("resp_data", {24'b0, resp_data}, {24'b0, e.data});
                    check("resp_is_write", {31'b0, resp_is_write}, {31'b0, e.is_write});
                end
            end
        end
    end

    // Issue one request: wait for ready, present it for the accept edge, then
    // present random garbage for one more edge (must be ignored while busy).
    task automatic issue(input logic w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, output int acc_cyc);
        int n = 0;
        acc_cyc = -1;
        while (!req_ready && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: req_ready=%0b required 1", req_ready);
            return;
        end
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        if (w) begin
            mem_model[a] = d;
            sb.push_back('{d, 1'b1});
            exp_stores++;
        end else begin
            sb.push_back('{mem_model[a], 1'b0});
            exp_loads++;
        end
        @(posedge clock);
        #1;
        acc_cyc   = cyc;
        req_write = 1'($urandom_range(0, 1));
        req_addr  = 4'($urandom_range(0, 15));
        req_wdata = 8'($urandom_range(0, 255));
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clock);
            n++;
        end
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_reset_values(input string p);
        check({p, "_req_ready"},      {31'b0, req_ready},      32'd0);
        check({p, "_resp_valid"},     {31'b0, resp_valid},     32'd0);
        check({p, "_mem_read"},       {31'b0, mem_read},       32'd0);
        check({p, "_mem_write"},      {31'b0, mem_write},      32'd0);
        check({p, "_resp_is_write"},  {31'b0, resp_is_write},  32'd0);
        check({p, "_resp_data"},      {24'b0, resp_data},      32'd0);
        check({p, "_mem_address"},    {28'b0, mem_address},    32'd0);
        check({p, "_mem_write_data"}, {24'b0, mem_write_data}, 32'd0);
        check({p, "_load_count"},     {24'b0, load_count},     32'd0);
        check({p, "_store_count"},    {24'b0, store_count},    32'd0);
    endtask

    task automatic check_counts(input string p);
        check({p, "_load_count"},  {24'b0, load_count},  32'(exp_loads % 256));
        check({p, "_store_count"}, {24'b0, store_count}, 32'(exp_stores % 256));
    endtask

    // Pulse reset mid-cycle
    task automatic pulse_reset(input string p);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values(p);
        #3;
        reset_n    = 1'b1;
        exp_loads  = 0;
        exp_stores = 0;
        sb.delete();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int acc;
        int prev_acc;
        for (int i = 0; i < 16; i++) mem_model[i] = init_val(i);
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;

        // Reset values while held, ready after release
        #3;
        check_reset_values("por");
        #9;
        reset_n = 1'b1;
        #1;
        check("por_release_req_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clock);
        #1;

        // Load addr 1: exact cycle timing
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 4'd1;
        sb.push_back('{mem_model[1], 1'b0});
        exp_loads++;
        @(posedge clock);
        #1;
        check("ld1_mem_read_n1",   {31'b0, mem_read},   32'd1);
        check("ld1_mem_write_n1",  {31'b0, mem_write},  32'd0);
        check("ld1_mem_address",   {28'b0, mem_address}, 32'd1);
        check("ld1_req_ready_n1",  {31'b0, req_ready},  32'd0);
        check("ld1_resp_valid_n1", {31'b0, resp_valid}, 32'd0);
        req_valid = 1'b0;
        @(posedge clock);
        #1;
        check("ld1_mem_read_n2",   {31'b0, mem_read},     32'd0);
        check("ld1_resp_valid_n2", {31'b0, resp_valid},   32'd1);
        check("ld1_resp_data",     {24'b0, resp_data},    32'd15);
        check("ld1_resp_is_write", {31'b0, resp_is_write}, 32'd0);
        @(posedge clock);
        #1;
        check("ld1_back_to_idle", {31'b0, req_ready}, 32'd1);
        check_counts("ld1");

        // Store 0xAA to addr 3, load it back
        issue(1'b1, 4'd3, 8'hAA, acc);
        issue(1'b0, 4'd3, 8'h00, acc);
        drain();
        check_counts("st_ld3");

        // Back-pressure: response held three cycles
        resp_ready = 1'b0;
        issue(1'b0, 4'd2, 8'h00, acc);
        for (int k = 0; k < 3; k++) begin
            check("bp_resp_valid", {31'b0, resp_valid}, 32'd1);
            check("bp_resp_data",  {24'b0, resp_data},  32'd5);
            check("bp_req_ready",  {31'b0, req_ready},  32'd0);
            check("bp_mem_read",   {31'b0, mem_read},   32'd0);
            check("bp_mem_write",  {31'b0, mem_write},  32'd0);
            @(posedge clock);
            #1;
        end
        resp_ready = 1'b1;
        @(posedge clock);
        #1;
        check("bp_release_req_ready",  {31'b0, req_ready},  32'd1);
        check("bp_release_resp_valid", {31'b0, resp_valid}, 32'd0);
        drain();
        check_counts("bp");

        // Reset mid-cycle during RD
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 4'd5;
        @(posedge clock);
        #1;
        check("rst_rd_in_rd", {31'b0, mem_read}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("rst_rd");
        req_valid = 1'b0;
        #3;
        reset_n    = 1'b1;
        exp_loads  = 0;
        exp_stores = 0;
        @(posedge clock);
        #1;

        // Reset mid-cycle during WR (store must not land)
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 4'd4;
        req_wdata = 8'h5A;
        @(posedge clock);
        #1;
        check("rst_wr_in_wr", {31'b0, mem_write}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("rst_wr");
        req_valid = 1'b0;
        #3;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("rst_wr_no_resp", {31'b0, resp_valid}, 32'd0);

        // After reset: load addr 2 returns 5; aborted store left addr 4 intact
        issue(1'b0, 4'd2, 8'h00, acc);
        issue(1'b0, 4'd4, 8'h00, acc);
        drain();
        check_counts("post_rst");

        // Randomized mix with random back-pressure
        rr_random = 1'b1;
        for (int k = 0; k < 60; k++) begin
            issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  8'($urandom_range(0, 255)), acc);
        end
        drain();
        rr_random = 1'b0;
        @(posedge clock);
        #1;
        resp_ready = 1'b1;
        check_counts("random");

        // 256 back-to-back loads: one accept per 3 cycles, load_count wraps
        pulse_reset("pre_b2b");
        prev_acc = -1;
        for (int k = 0; k < 256; k++) begin
            issue(1'b0, 4'($urandom_range(0, 15)), 8'h00, acc);
            if (k > 0) check("b2b_accept_spacing", 32'(acc - prev_acc), 32'd3);
            prev_acc = acc;
        end
        drain();
        @(posedge clock);
        #1;
        check_counts("b2b_wrap");
        check("b2b_load_count_zero", {24'b0, load_count}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_load_store_unit
